// File: rtl/e_mdu_ctrl.sv
// e_mdu_ctrl: E-stage multiply/divide controller. Owns HI/LO, sequences
// mult/multu/div/divu with fixed latencies, serves mfhi/mflo/mthi/mtlo and
// raises the D-stage stall for colliding MD instructions.
// Optional feature macro: MDU_MADD_EN enables madd/maddu/msub/msubu (ops 9-12).
//
// state   | meaning
// ST_IDLE | nothing in flight; MD starts and mthi/mtlo writes are accepted
// ST_BUSY | down-counting; pending result commits on terminal count (cnt == 1)
module e_mdu_ctrl #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_valid,
  input  logic        i_flush,
  input  logic [3:0]  i_mdOp,
  input  logic [31:0] i_srcA,
  input  logic [31:0] i_srcB,
  input  logic        i_dIsMD,
  output logic        o_busy,
  output logic        o_stall,
  output logic [31:0] o_rdata,
  output logic [31:0] o_hi,
  output logic [31:0] o_lo
);
  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW = $clog2(MAX_CYCLES + 1);
  localparam logic [CW-1:0] MULT_LOAD = CW'(MULT_CYCLES);
  localparam logic [CW-1:0] DIV_LOAD  = CW'(DIV_CYCLES);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MFHI  = 4'd5;
  localparam logic [3:0] OP_MFLO  = 4'd6;
  localparam logic [3:0] OP_MTHI  = 4'd7;
  localparam logic [3:0] OP_MTLO  = 4'd8;
`ifdef MDU_MADD_EN
  localparam logic [3:0] OP_MADD  = 4'd9;
  localparam logic [3:0] OP_MADDU = 4'd10;
  localparam logic [3:0] OP_MSUB  = 4'd11;
  localparam logic [3:0] OP_MSUBU = 4'd12;
`endif

  typedef enum logic {ST_IDLE, ST_BUSY} state_t;
  typedef enum logic [1:0] {CM_LOAD, CM_ADD, CM_SUB} cmode_t;

  state_t      state_q, state_d;
  cmode_t      mode_q, mode_d, mode_sel;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [63:0] pend_q, pend_d;
  logic [31:0] hi_q, hi_d, lo_q, lo_d;

  logic        is_mul, is_div, is_mac, is_signed, acc, start_now;
  logic [63:0] a_ext, b_ext, prod, div_res, pend_sel, commit;
  logic [31:0] a_mag, b_mag, b_div, uq, ur, q, r;
  logic        neg_q, neg_r;

  // Opcode decode and the accept/start qualification.
  always_comb begin
    is_mul    = (i_mdOp == OP_MULT) || (i_mdOp == OP_MULTU);
    is_div    = (i_mdOp == OP_DIV)  || (i_mdOp == OP_DIVU);
    is_signed = (i_mdOp == OP_MULT) || (i_mdOp == OP_DIV);
    is_mac    = 1'b0;
    mode_sel  = CM_LOAD;
`ifdef MDU_MADD_EN
    is_mac = (i_mdOp >= OP_MADD) && (i_mdOp <= OP_MSUBU);
    if ((i_mdOp == OP_MADD) || (i_mdOp == OP_MSUB))  is_signed = 1'b1;
    if ((i_mdOp == OP_MADD) || (i_mdOp == OP_MADDU)) mode_sel  = CM_ADD;
    if ((i_mdOp == OP_MSUB) || (i_mdOp == OP_MSUBU)) mode_sel  = CM_SUB;
`endif
    acc       = i_valid & ~i_flush & (state_q == ST_IDLE);
    start_now = acc & (is_mul | is_div | is_mac);
  end

  // Result datapath: 64-bit product and a sign-magnitude divider. Working on
  // magnitudes makes 0x80000000 / -1 fall out as quotient 0x80000000, rem 0.
  always_comb begin
    a_ext = is_signed ? {{32{i_srcA[31]}}, i_srcA} : {32'd0, i_srcA};
    b_ext = is_signed ? {{32{i_srcB[31]}}, i_srcB} : {32'd0, i_srcB};
    prod  = a_ext * b_ext;
    neg_r = is_signed & i_srcA[31];
    neg_q = is_signed & (i_srcA[31] ^ i_srcB[31]);
    a_mag = neg_r ? -i_srcA : i_srcA;
    b_mag = (is_signed & i_srcB[31]) ? -i_srcB : i_srcB;
    b_div = (i_srcB == 32'd0) ? 32'd1 : b_mag;
    uq    = a_mag / b_div;
    ur    = a_mag % b_div;
    q     = neg_q ? -uq : uq;
    r     = neg_r ? -ur : ur;
    div_res  = (i_srcB == 32'd0) ? {i_srcA, 32'hFFFF_FFFF} : {r, q};
    pend_sel = is_div ? div_res : prod;
  end

  // Next-state: countdown/commit while busy, otherwise start or mthi/mtlo.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pend_d  = pend_q;
    mode_d  = mode_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    case (mode_q)
      CM_ADD:  commit = {hi_q, lo_q} + pend_q;
      CM_SUB:  commit = {hi_q, lo_q} - pend_q;
      default: commit = pend_q;
    endcase
    if (state_q == ST_BUSY) begin
      cnt_d = cnt_q - CNT_ONE;
      if (cnt_q == CNT_ONE) begin
        state_d      = ST_IDLE;
        {hi_d, lo_d} = commit;
      end
    end else if (start_now) begin
      state_d = ST_BUSY;
      cnt_d   = is_div ? DIV_LOAD : MULT_LOAD;
      pend_d  = pend_sel;
      mode_d  = mode_sel;
    end else if (acc && (i_mdOp == OP_MTHI)) begin
      hi_d = i_srcA;
    end else if (acc && (i_mdOp == OP_MTLO)) begin
      lo_d = i_srcA;
    end
  end

  // State registers with synchronous reset taking priority over everything.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      pend_q  <= '0;
      mode_q  <= CM_LOAD;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
      mode_q  <= mode_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  // Outputs: busy from state, stall covers the start cycle, mf reads are combinational.
  always_comb begin
    o_busy  = (state_q == ST_BUSY);
    o_stall = i_dIsMD & (o_busy | start_now);
    o_hi    = hi_q;
    o_lo    = lo_q;
    o_rdata = 32'd0;
    if (i_mdOp == OP_MFHI) o_rdata = hi_q;
    else if (i_mdOp == OP_MFLO) o_rdata = lo_q;
  end
endmodule

// File: tb/tb_e_mdu_ctrl.sv
// Self-checking bench for e_mdu_ctrl: directed cases plus randomized MD
// traffic checked against an arithmetic model of HI/LO.
module tb_e_mdu_ctrl;
  localparam int MULT_N = 5;
  localparam int DIV_N  = 10;

  logic        clk = 1'b0;
  logic        reset;
  logic        i_valid, i_flush, i_dIsMD;
  logic [3:0]  i_mdOp;
  logic [31:0] i_srcA, i_srcB;
  logic        o_busy, o_stall;
  logic [31:0] o_rdata, o_hi, o_lo;

  int n_chk  = 0;
  int n_fail = 0;
  logic [31:0] m_hi = 32'd0;
  logic [31:0] m_lo = 32'd0;

  e_mdu_ctrl #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N)) dut (
    .clk(clk), .reset(reset), .i_valid(i_valid), .i_flush(i_flush),
    .i_mdOp(i_mdOp), .i_srcA(i_srcA), .i_srcB(i_srcB), .i_dIsMD(i_dIsMD),
    .o_busy(o_busy), .o_stall(o_stall), .o_rdata(o_rdata),
    .o_hi(o_hi), .o_lo(o_lo)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Architectural result of an MD op from plain 64-bit arithmetic.
  function automatic logic [63:0] model(input logic [3:0] op, input logic [31:0] a,
                                        input logic [31:0] b, input logic [63:0] hilo);
    longint sa, sb, sq, sr;
    longint unsigned ua, ub, uq, ur;
    logic [63:0] res;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    res = hilo;
    case (op)
      4'd1: res = sa * sb;
      4'd2: res = ua * ub;
      4'd3: if (b == 32'd0) res = {a, 32'hFFFF_FFFF};
            else begin
              sq = sa / sb; sr = sa % sb;
              res = {sr[31:0], sq[31:0]};
            end
      4'd4: if (b == 32'd0) res = {a, 32'hFFFF_FFFF};
            else begin
              uq = ua / ub; ur = ua % ub;
              res = {ur[31:0], uq[31:0]};
            end
      4'd9:  res = hilo + 64'(sa * sb);
      4'd10: res = hilo + 64'(ua * ub);
      4'd11: res = hilo - 64'(sa * sb);
      4'd12: res = hilo - 64'(ua * ub);
      default: res = hilo;
    endcase
    return res;
  endfunction

  task automatic idle_inputs();
    i_valid = 1'b0; i_flush = 1'b0; i_mdOp = 4'd0;
  endtask

  // Issue one multi-cycle op; optionally fire ignored traffic while busy.
  task automatic run_md(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic dmd, input bit noise);
    logic [63:0] exp;
    int n;
    exp = model(op, a, b, {m_hi, m_lo});
    n = ((op == 4'd3) || (op == 4'd4)) ? DIV_N : MULT_N;
    i_valid = 1'b1; i_flush = 1'b0; i_mdOp = op; i_srcA = a; i_srcB = b; i_dIsMD = dmd;
    #1;
    chk("idle_before_start", {63'd0, o_busy}, 64'd0);
    chk("stall_start", {63'd0, o_stall}, {63'd0, dmd});
    tick();
    idle_inputs();
    for (int k = 1; k <= n; k++) begin
      if (noise) begin
        i_valid = 1'b1;
        i_flush = 1'($urandom_range(0, 1));
        i_mdOp  = 4'($urandom_range(1, 8));
        i_srcA  = $urandom;
        i_srcB  = $urandom;
      end
      #1;
      chk("busy", {63'd0, o_busy}, 64'd1);
      chk("stall_busy", {63'd0, o_stall}, {63'd0, dmd});
      chk("hilo_hold", {o_hi, o_lo}, {m_hi, m_lo});
      tick();
    end
    idle_inputs();
    #1;
    chk("busy_done", {63'd0, o_busy}, 64'd0);
    chk("stall_done", {63'd0, o_stall}, 64'd0);
    chk("hilo_commit", {o_hi, o_lo}, exp);
    {m_hi, m_lo} = exp;
  endtask

  // mthi/mtlo: visible next cycle unless flushed.
  task automatic run_mt(input logic [3:0] op, input logic [31:0] a, input logic fl);
    i_valid = 1'b1; i_flush = fl; i_mdOp = op; i_srcA = a; i_srcB = $urandom;
    tick();
    idle_inputs();
    if (!fl) begin
      if (op == 4'd7) m_hi = a;
      else m_lo = a;
    end
    #1;
    chk("mt_nobusy", {63'd0, o_busy}, 64'd0);
    chk("mt_hilo", {o_hi, o_lo}, {m_hi, m_lo});
  endtask

  task automatic mf_check();
    i_mdOp = 4'd5; #1;
    chk("mfhi", {32'd0, o_rdata}, {32'd0, m_hi});
    i_mdOp = 4'd6; #1;
    chk("mflo", {32'd0, o_rdata}, {32'd0, m_lo});
    i_mdOp = 4'd0; #1;
    chk("rdata_none", {32'd0, o_rdata}, 64'd0);
  endtask

  initial begin
    logic [3:0] op;
    logic [31:0] a, b;
    int sel;
    reset = 1'b1; i_dIsMD = 1'b0; i_srcA = 32'd0; i_srcB = 32'd0;
    idle_inputs();
    tick(); tick();
    reset = 1'b0;
    #1;
    chk("rst_busy", {63'd0, o_busy}, 64'd0);
    chk("rst_stall", {63'd0, o_stall}, 64'd0);
    chk("rst_hilo", {o_hi, o_lo}, 64'd0);
    chk("rst_rdata", {32'd0, o_rdata}, 64'd0);

    run_md(4'd1, 32'hFFFF_FFFE, 32'd3, 1'b1, 1'b0);
    chk("mult_const", {o_hi, o_lo}, 64'hFFFF_FFFF_FFFF_FFFA);
    run_md(4'd2, 32'hFFFF_FFFE, 32'd3, 1'b0, 1'b0);
    chk("multu_const", {o_hi, o_lo}, 64'h0000_0002_FFFF_FFFA);
    run_md(4'd3, 32'hFFFF_FFF9, 32'd2, 1'b0, 1'b0);
    chk("div_neg_const", {o_hi, o_lo}, 64'hFFFF_FFFF_FFFF_FFFD);
    run_md(4'd3, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0);
    chk("div_ovf_const", {o_hi, o_lo}, 64'h0000_0000_8000_0000);
    run_md(4'd4, 32'd5, 32'd0, 1'b0, 1'b0);
    chk("divu_zero_const", {o_hi, o_lo}, 64'h0000_0005_FFFF_FFFF);
    run_md(4'd3, 32'd9, 32'd0, 1'b0, 1'b0);
    chk("div_zero_const", {o_hi, o_lo}, 64'h0000_0009_FFFF_FFFF);
    // Second mult and flushes during busy must be ignored.
    run_md(4'd1, 32'd1234, 32'hFFFF_FF00, 1'b1, 1'b1);

    run_mt(4'd8, 32'h0000_1234, 1'b1);
    run_mt(4'd8, 32'h0000_1234, 1'b0);
    mf_check();
    chk("mflo_const", {32'd0, m_lo}, 64'h1234);
    run_mt(4'd7, 32'hCAFE_0001, 1'b0);
    mf_check();

    // Reset in busy cycle 3 of a divide: nothing commits afterwards.
    i_valid = 1'b1; i_mdOp = 4'd3; i_srcA = 32'd100; i_srcB = 32'd7;
    tick();
    idle_inputs();
    tick(); tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    m_hi = 32'd0; m_lo = 32'd0;
    #1;
    chk("rst_mid_busy", {63'd0, o_busy}, 64'd0);
    chk("rst_mid_hilo", {o_hi, o_lo}, 64'd0);
    repeat (DIV_N + 2) tick();
    chk("rst_no_commit", {o_hi, o_lo}, 64'd0);
    chk("rst_no_busy", {63'd0, o_busy}, 64'd0);

`ifdef MDU_MADD_EN
    run_mt(4'd7, 32'd0, 1'b0);
    run_mt(4'd8, 32'hFFFF_FFFF, 1'b0);
    run_md(4'd10, 32'd1, 32'd1, 1'b0, 1'b0);
    chk("maddu_carry", {o_hi, o_lo}, 64'h0000_0001_0000_0000);
    run_md(4'd11, 32'hFFFF_FFFF, 32'd3, 1'b0, 1'b0);
`else
    run_mt(4'd7, 32'h0BAD_F00D, 1'b0);
    i_valid = 1'b1; i_mdOp = 4'd9; i_srcA = 32'd7; i_srcB = 32'd9; i_dIsMD = 1'b1;
    #1;
    chk("op9_nostall", {63'd0, o_stall}, 64'd0);
    tick();
    idle_inputs();
    i_dIsMD = 1'b0;
    #1;
    chk("op9_nobusy", {63'd0, o_busy}, 64'd0);
    chk("op9_hilo", {o_hi, o_lo}, {m_hi, m_lo});
`endif

    for (int it = 0; it < 40; it++) begin
      sel = int'($urandom_range(0, 5));
      a = $urandom;
      b = $urandom;
      if ($urandom_range(0, 7) == 0) b = 32'd0;
      if ($urandom_range(0, 7) == 0) a = 32'h8000_0000;
      if (sel < 4) begin
        op = 4'(sel + 1);
`ifdef MDU_MADD_EN
        if ($urandom_range(0, 2) == 0) op = 4'(sel + 9);
`endif
        run_md(op, a, b, 1'($urandom_range(0, 1)), 1'b1);
      end else begin
        run_mt(4'(sel + 3), a, 1'($urandom_range(0, 1)));
      end
      mf_check();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/e_mdu_ctrl.md
# e_mdu_ctrl

Multi-cycle multiply/divide controller for the E stage of the pipelined MIPS core, running beside the single-cycle ALU. It owns the HI/LO register pair, sequences mult/multu/div/divu with fixed, configurable latencies, and serves mfhi/mflo/mthi/mtlo. It also produces the busy/stall signal the hazard unit uses to freeze D when an MD-class instruction would collide with an operation in flight.

## Interface
Parameters:
- MULT_CYCLES, 5, busy cycles for mult/multu (≥1)
- DIV_CYCLES, 10, busy cycles for div/divu (≥1)

Ports:
- clk  in  1  clock, all state updates on rising edge
- reset  in  1  synchronous, active-high; clears all state
- i_valid  in  1  E-stage instruction is valid this cycle
- i_flush  in  1  E-stage instruction is cancelled by an exception/interrupt (blocks start and writes)
- i_mdOp  in  4  0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mfhi, 6 mflo, 7 mthi, 8 mtlo (9–12 see Configuration)
- i_srcA  in  32  rs value (forwarded)
- i_srcB  in  32  rt value (forwarded)
- i_dIsMD  in  1  D-stage instruction has a nonzero MD op
- o_busy  out  1  operation in flight
- o_stall  out  1  stall request to hazard unit
- o_rdata  out  32  HI for mfhi, LO for mflo, else 0
- o_hi, o_lo  out  32  architectural HI/LO

## Operation
- Accept condition: acc = i_valid & ~i_flush & ~o_busy.
- Start: acc & op∈{1..4}.
  - Operands latch, pending result computes, counter loads MULT_CYCLES or DIV_CYCLES.
- mult: {HI,LO} = signed 64-bit product. multu: unsigned product.
- div: LO = quotient truncated toward zero; HI = remainder with the dividend's sign. divu: unsigned.
- Divide by zero: LO = 0xFFFFFFFF, HI = srcA (both signed and unsigned).
- Signed overflow 0x80000000 / 0xFFFFFFFF: LO = 0x80000000, HI = 0.
- mthi/mtlo: on acc, HI or LO = i_srcA at the clock edge. No busy, no delay.
- mfhi/mflo: o_rdata is combinational from the current HI/LO.
- Any MD op presented while o_busy is a protocol violation. It is ignored: no start, no write.
- o_stall = i_dIsMD & (o_busy | start_now), where start_now is the combinational start condition.
- i_flush during busy does not abort; the issued operation commits.

## Timing
- Reset values: o_busy 0, o_stall 0 (given i_dIsMD=0), HI 0, LO 0, counter 0, o_rdata 0.
- Start sampled at edge ending cycle T → o_busy=1 in cycles T+1..T+N (N = configured cycles).
- HI/LO update at the edge ending T+N. In T+N+1, o_busy=0 and the new values are visible.
- Back-to-back: a new start is accepted in cycle T+N+1 at the earliest.
- mthi/mtlo in cycle T → visible in cycle T+1.
- Reset mid-operation: counter cleared, pending result discarded, HI/LO = 0 next cycle.
- Reset has priority over start, write and commit.

## Configuration
- MDU_MADD_EN defined:
  - op 9 madd: {HI,LO} += signed product
  - op 10 maddu: {HI,LO} += unsigned product
  - op 11 msub: {HI,LO} −= signed product
  - op 12 msubu: {HI,LO} −= unsigned product
  - All four use MULT_CYCLES, wrap modulo 2^64, and accumulate into the {HI,LO} value at commit time.
- MDU_MADD_EN undefined: ops 9–15 behave as op 0 (no effect, no busy).

## Test plan
- mult 0xFFFFFFFE × 0x00000003 → after 5 busy cycles HI=0xFFFFFFFF, LO=0xFFFFFFFA. Same operands with multu → HI=0x00000002, LO=0xFFFFFFFA.
- div −7 / 2 → after 10 busy cycles LO=0xFFFFFFFD, HI=0xFFFFFFFF. div 0x80000000 / 0xFFFFFFFF → LO=0x80000000, HI=0. divu 5 / 0 → LO=0xFFFFFFFF, HI=5.
- Start mult, hold i_dIsMD=1 → o_stall high in the start cycle and every busy cycle, low the cycle HI/LO become valid. A second mult issued during busy is ignored.
- mtlo 0x1234 with i_flush=1 → LO unchanged. Without flush → mflo returns 0x1234 next cycle. i_flush during busy → result still commits.
- reset asserted in busy cycle 3 of div → o_busy=0, HI=LO=0 next cycle, no later commit.
- With MDU_MADD_EN: HI=0, LO=0xFFFFFFFF, maddu 1×1 → HI=1, LO=0. Without MDU_MADD_EN: op 9 → no busy, HI/LO unchanged.
